// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding and sizing constants for the conv layer controller.
package cnn_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_MAP,
      S_CONV,
      S_POOL,
      S_DONE
   } state_t;
   localparam int COL_DEF = 32;
   localparam int ROW_DEF = 25;
   localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;
endpackage

// File: rtl/ctrl_beat_cnt.sv
// ctrl_beat_cnt: beat counter that wraps to zero after i_last and flags the terminal beat.
module ctrl_beat_cnt #(
   parameter int W = 5
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt,
   output logic         o_term
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_term ? '0 : r_cnt + W'(1);
   end
   assign o_cnt  = r_cnt;
   assign o_term = r_cnt == i_last;
endmodule

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequences one CNN layer - weight columns, feature-map stream, conv, pool.
// Defining CONV_CTRL_TIMEOUT_EN adds a 16-bit CONV+POOL watchdog that aborts with err.
module conv_layer_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COL        = COL_DEF,
   parameter int ROW        = ROW_DEF
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [4:0]     weight_dim,
   input  logic [5:0]     num_filter,
   input  logic [9:0]     map_len,
   input  logic           w_valid,
   output logic           w_ready,
   input  logic           map_valid,
   output logic           map_ready,
   input  logic           conv_finish,
   input  logic           pool_finish,
   output logic [COL-1:0] weight_en,
   output logic           fifo_en,
   output logic           conv_ctrl,
   output logic           flag_start,
   output logic           busy,
   output logic           done,
   output logic           err
);
   localparam logic [6:0] COL_L = 7'(COL);
   localparam logic [5:0] ROW_L = 6'(ROW);

   if (DATA_WIDTH < 1 || COL < 1 || ROW < 1) begin : g_bad_param
      $error("conv_layer_ctrl: DATA_WIDTH, COL and ROW must be positive");
   end

   state_t      r_state, w_next;
   logic [4:0]  r_wdim;
   logic [5:0]  r_nfilt;
   logic [9:0]  r_mlen;
   logic        r_err, r_flag_start, r_conv_done;
   logic        w_cfg_ok, w_err_set, w_timeout, w_idle;
   logic        w_word_term, w_col_term, w_map_term, w_w_beat, w_m_beat;
   logic [4:0]  w_word_cnt;
   logic [5:0]  w_col;
   logic [9:0]  w_map_cnt;
   logic        w_unused;

   assign w_idle   = r_state == S_IDLE;
   assign w_cfg_ok = num_filter != '0 && {1'b0, num_filter} <= COL_L &&
                     weight_dim != '0 && {1'b0, weight_dim} <= ROW_L && map_len != '0;
   assign w_w_beat = r_state == S_LOAD_W && w_valid;
   assign w_m_beat = r_state == S_LOAD_MAP && map_valid;
   assign w_unused = ^{w_word_cnt, w_map_cnt};

   ctrl_beat_cnt #(.W(5)) u_word_cnt (
      .clk(clk), .rst(rst), .i_clr(w_idle), .i_en(w_w_beat),
      .i_last(r_wdim - 5'd1), .o_cnt(w_word_cnt), .o_term(w_word_term)
   );
   ctrl_beat_cnt #(.W(6)) u_col_cnt (
      .clk(clk), .rst(rst), .i_clr(w_idle), .i_en(w_w_beat && w_word_term),
      .i_last(r_nfilt - 6'd1), .o_cnt(w_col), .o_term(w_col_term)
   );
   ctrl_beat_cnt #(.W(10)) u_map_cnt (
      .clk(clk), .rst(rst), .i_clr(w_idle), .i_en(w_m_beat),
      .i_last(r_mlen - 10'd1), .o_cnt(w_map_cnt), .o_term(w_map_term)
   );

`ifdef CONV_CTRL_TIMEOUT_EN
   logic [15:0] r_wdog;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_wdog <= '0;
      else r_wdog <= (r_state == S_CONV || r_state == S_POOL) ? r_wdog + 16'd1 : '0;
   end
   assign w_timeout = r_wdog == TIMEOUT_LIMIT &&
                      ((r_state == S_CONV && !r_conv_done) || (r_state == S_POOL && !pool_finish));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_err_set = 1'b0;
      case (r_state)
         S_IDLE:     if (start) begin
                        w_next    = w_cfg_ok ? S_LOAD_W : S_IDLE;
                        w_err_set = !w_cfg_ok;
                     end
         S_LOAD_W:   if (w_w_beat && w_word_term && w_col_term) w_next = S_LOAD_MAP;
         S_LOAD_MAP: if (w_m_beat && w_map_term) w_next = S_CONV;
         S_CONV:     if (r_conv_done) w_next = S_POOL;
         S_POOL:     if (pool_finish) w_next = S_DONE;
         default:    w_next = S_IDLE;
      endcase
      if (w_timeout) begin
         w_next    = S_IDLE;
         w_err_set = 1'b1;
      end
   end

   // conv_finish may arrive any time after LOAD_MAP entry, so it is held until CONV consumes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_err        <= 1'b0;
         r_flag_start <= 1'b0;
         r_conv_done  <= 1'b0;
         r_wdim       <= '0;
         r_nfilt      <= '0;
         r_mlen       <= '0;
      end else begin
         r_state      <= w_next;
         r_err        <= w_err_set;
         r_flag_start <= r_state == S_LOAD_W && w_next == S_LOAD_MAP;
         r_conv_done  <= (r_state == S_LOAD_MAP || r_state == S_CONV) && (r_conv_done || conv_finish);
         if (w_idle && start && w_cfg_ok) begin
            r_wdim  <= weight_dim;
            r_nfilt <= num_filter;
            r_mlen  <= map_len;
         end
      end
   end

   assign busy       = !w_idle;
   assign done       = r_state == S_DONE;
   assign err        = r_err;
   assign w_ready    = r_state == S_LOAD_W;
   assign map_ready  = r_state == S_LOAD_MAP;
   assign fifo_en    = w_m_beat;
   assign conv_ctrl  = r_state == S_LOAD_MAP || r_state == S_CONV;
   assign flag_start = r_flag_start;
   assign weight_en  = w_w_beat ? COL'(1) << w_col : '0;
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// tb_conv_layer_ctrl: directed scoreboard bench; expected output events are queued as stimulus is driven.
module tb_conv_layer_ctrl;
   localparam int COL = 32;
   localparam logic [7:0] EV_W = 8'd1, EV_FS = 8'd2, EV_F = 8'd3, EV_D = 8'd4, EV_E = 8'd5;

   logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [4:0]     weight_dim = '0;
   logic [5:0]     num_filter = '0;
   logic [9:0]     map_len = '0;
   logic           w_valid = 1'b0, map_valid = 1'b0, conv_finish = 1'b0, pool_finish = 1'b0;
   logic           w_ready, map_ready, fifo_en, conv_ctrl, flag_start, busy, done, err;
   logic [COL-1:0] weight_en;
   logic [39:0]    exp_q[$];
   int             total = 0, bad = 0;

   conv_layer_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .weight_dim(weight_dim), .num_filter(num_filter),
      .map_len(map_len), .w_valid(w_valid), .w_ready(w_ready), .map_valid(map_valid),
      .map_ready(map_ready), .conv_finish(conv_finish), .pool_finish(pool_finish),
      .weight_en(weight_en), .fifo_en(fifo_en), .conv_ctrl(conv_ctrl), .flag_start(flag_start),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] kind, input logic [31:0] val);
      exp_q.push_back({kind, val});
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] kind, input logic [31:0] val);
      logic [39:0] e;
      e = exp_q.size() != 0 ? exp_q.pop_front() : 40'h0;
      chk(tag, {24'h0, kind, val}, {24'h0, e});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (weight_en != '0) pop_chk("weight_en", EV_W, weight_en);
      if (flag_start) pop_chk("flag_start", EV_FS, 32'h0);
      if (fifo_en) pop_chk("fifo_en", EV_F, 32'h0);
      if (done) pop_chk("done", EV_D, 32'h0);
      if (err) pop_chk("err", EV_E, 32'h0);
   end

   function automatic logic [63:0] outs();
      return {24'h0, busy, done, err, w_ready, map_ready, fifo_en, conv_ctrl, flag_start, weight_en};
   endfunction

   task automatic bad_start(input string tag, input logic [4:0] wd, input logic [5:0] nf, input logic [9:0] ml);
      weight_dim = wd; num_filter = nf; map_len = ml; start = 1'b1;
      push(EV_E, 32'h0);
      cyc();
      start = 1'b0;
      chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
      cyc();
      chk({tag, "_err_pulse"}, {63'h0, err}, 64'h0);
   endtask

   initial begin
      cyc();
      chk("reset_outs", outs(), 64'h0);
      rst = 1'b0;
      cyc();
      chk("idle_outs", outs(), 64'h0);

      bad_start("nf0", 5'd3, 6'd0, 10'd4);
      bad_start("wd26", 5'd26, 6'd2, 10'd4);
      bad_start("ml0", 5'd3, 6'd2, 10'd0);
      bad_start("nf33", 5'd3, 6'd33, 10'd4);

      // 3 weights x 2 filters, 4 map beats, back-to-back valids
      weight_dim = 5'd3; num_filter = 6'd2; map_len = 10'd4; start = 1'b1;
      cyc();
      start = 1'b0;
      weight_dim = 5'd1; num_filter = 6'd1; map_len = 10'd1;
      chk("loadw_ready", {62'h0, busy, w_ready}, 64'h3);
      for (int i = 0; i < 6; i++) begin
         w_valid = 1'b1;
         push(EV_W, i < 3 ? 32'h1 : 32'h2);
         cyc();
      end
      w_valid = 1'b0;
      push(EV_FS, 32'h0);
      chk("loadmap_flags", {61'h0, w_ready, map_ready, conv_ctrl}, 64'h3);
      for (int i = 0; i < 4; i++) begin
         map_valid = 1'b1;
         push(EV_F, 32'h0);
         cyc();
      end
      map_valid = 1'b0;
      chk("conv_flags", {61'h0, map_ready, conv_ctrl, busy}, 64'h3);
      cyc();
      cyc();
      chk("conv_waits", {62'h0, conv_ctrl, busy}, 64'h3);
      conv_finish = 1'b1;
      cyc();
      conv_finish = 1'b0;
      cyc();
      chk("pool_flags", {62'h0, conv_ctrl, busy}, 64'h1);
      pool_finish = 1'b1;
      push(EV_D, 32'h0);
      cyc();
      pool_finish = 1'b0;
      cyc();
      chk("back_idle", outs(), 64'h0);

      // w_valid toggling 1010, conv_finish on the final map beat
      weight_dim = 5'd2; num_filter = 6'd3; map_len = 10'd1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         w_valid = i % 2 == 0;
         if (i % 2 == 0) push(EV_W, 32'h1 << (i / 4));
         cyc();
      end
      w_valid = 1'b0;
      push(EV_FS, 32'h0);
      chk("toggle_loadmap", {62'h0, map_ready, w_ready}, 64'h2);
      map_valid = 1'b1;
      conv_finish = 1'b1;
      push(EV_F, 32'h0);
      cyc();
      map_valid = 1'b0;
      conv_finish = 1'b0;
      chk("coinc_conv", {62'h0, conv_ctrl, map_ready}, 64'h2);
      cyc();
      chk("coinc_pool", {62'h0, conv_ctrl, busy}, 64'h1);
      pool_finish = 1'b1;
      push(EV_D, 32'h0);
      cyc();
      pool_finish = 1'b0;
      cyc();

      // reset in the middle of LOAD_MAP, then restart from column 0
      weight_dim = 5'd1; num_filter = 6'd1; map_len = 10'd8; start = 1'b1;
      cyc();
      start = 1'b0;
      w_valid = 1'b1;
      push(EV_W, 32'h1);
      cyc();
      w_valid = 1'b0;
      push(EV_FS, 32'h0);
      map_valid = 1'b1;
      push(EV_F, 32'h0);
      cyc();
      push(EV_F, 32'h0);
      cyc();
      chk("pre_rst_fifo", {63'h0, fifo_en}, 64'h1);
      rst = 1'b1;
      #1;
      chk("rst_async_outs", outs(), 64'h0);
      map_valid = 1'b0;
      cyc();
      rst = 1'b0;
      weight_dim = 5'd1; num_filter = 6'd2; map_len = 10'd1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w_valid = 1'b1;
         push(EV_W, 32'h1 << i);
         cyc();
      end
      w_valid = 1'b0;
      push(EV_FS, 32'h0);
      map_valid = 1'b1;
      push(EV_F, 32'h0);
      cyc();
      map_valid = 1'b0;
      conv_finish = 1'b1;
      cyc();
      conv_finish = 1'b0;
      cyc();
      pool_finish = 1'b1;
      push(EV_D, 32'h0);
      cyc();
      pool_finish = 1'b0;
      cyc();
      chk("final_idle", outs(), 64'h0);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
